stopwatch_ctrl: RTL and testbench

Control front end for the stopwatch counter chain. It synchronises and debounces the two raw push-buttons (start/stop, lap/clear) and runs the stopwatch state machine. It divides the system clock down to a 100 Hz single-cycle `cnt_enable` pulse, and issues the clear and lap-hold controls consumed by the BCD counter chain and the display path.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 100 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control front end.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StLap   = 2'b11
   } sw_state_e;

   localparam int unsigned DefDbCycles = 1_000_000;
   localparam int unsigned DefTickDiv  = 1_000_000;

   // Counting continues while a lap time is frozen on the display.
   function automatic logic is_counting(sw_state_e s);
      return (s == StRun) || (s == StLap);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control/status outputs of the stopwatch control front end.
interface stopwatch_ctrl_if;

   logic       btn_start;
   logic       btn_lap;
   logic       cnt_enable;
   logic       sw_clear;
   logic       running;
   logic       lap_hold;
   logic [1:0] state;

   modport master (
      output btn_start, btn_lap,
      input  cnt_enable, sw_clear, running, lap_hold, state
   );

   modport slave (
      input  btn_start, btn_lap,
      output cnt_enable, sw_clear, running, lap_hold, state
   );

endinterface

// File: rtl/btn_debounce.sv
// Synchroniser, debounce counter and registered rising-edge press pulse for one button.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DefDbCycles
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

   logic [1:0]      sync_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            level_dly_q;
   logic            press_q;

   // Any return to the accepted level restarts the stability count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], btn};
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch state machine and 100 Hz count prescaler, fed by two debounced buttons.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DefDbCycles,
   parameter int unsigned TICK_DIV  = DefTickDiv
) (
   input  logic             clk,
   input  logic             rst,
   stopwatch_ctrl_if.slave  bus
);

   localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

   logic              start_p, lap_p;
   sw_state_e         state_q, state_d;
   logic              clear_q, clear_d;
   logic              tick_q, tick_d;
   logic [PrescW-1:0] presc_q, presc_d;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.btn_start),
      .press (start_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.btn_lap),
      .press (lap_p)
   );

   // Start is tested first everywhere so a coincident lap press is dropped.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_p)    state_d = StRun;
            else if (lap_p) clear_d = 1'b1;
         end
         StRun: begin
            if (start_p)    state_d = StPause;
            else if (lap_p) state_d = StLap;
         end
         StLap: begin
            if (start_p)    state_d = StPause;
            else if (lap_p) state_d = StRun;
         end
         StPause: begin
            if (start_p) begin
               state_d = StRun;
            end else if (lap_p) begin
               state_d = StIdle;
               clear_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (state_q == StIdle) begin
         presc_d = '0;
      end else if (is_counting(state_q)) begin
         if (presc_q == PrescLast) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         clear_q <= 1'b0;
         tick_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
         tick_q  <= tick_d;
         presc_q <= presc_d;
      end
   end

   assign bus.cnt_enable = tick_q;
   assign bus.sw_clear   = clear_q;
   assign bus.running    = is_counting(state_q);
   assign bus.lap_hold   = (state_q == StLap);
   assign bus.state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DB_CYCLES=4, TICK_DIV=10.
module tb_stopwatch_ctrl;

   typedef struct {
      int         cyc;
      logic       ce;
      logic       clr;
      logic [1:0] st;
      logic       hold;
      logic       run;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   bit   done = 1'b0;
   int   n_tests = 0;
   int   n_fails = 0;
   ev_t  exp_q[$];

   stopwatch_ctrl_if sw_if ();

   stopwatch_ctrl #(.DB_CYCLES(4), .TICK_DIV(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sw_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int c, input logic ce, input logic clr,
                            input logic [1:0] st, input logic hold);
      ev_t e;
      e.cyc  = c;
      e.ce   = ce;
      e.clr  = clr;
      e.st   = st;
      e.hold = hold;
      e.run  = (st == 2'b01) || (st == 2'b11);
      exp_q.push_back(e);
   endtask

   task automatic goto(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Raw level rises between edge t and t+1 and is held for 12 cycles.
   task automatic press(input int t, input logic s, input logic l);
      goto(t);
      sw_if.btn_start = s;
      sw_if.btn_lap   = l;
      goto(t + 12);
      sw_if.btn_start = 1'b0;
      sw_if.btn_lap   = 1'b0;
   endtask

   // Monitor: every cnt_enable, sw_clear or state change pops one expected event.
   initial begin : monitor
      ev_t        e;
      logic [1:0] prev_st;
      prev_st = 2'b00;
      forever begin
         @(negedge clk or negedge rst);
         if (!rst) begin
            #1;
            n_tests++;
            if ({sw_if.cnt_enable, sw_if.sw_clear, sw_if.running, sw_if.lap_hold,
                 sw_if.state} !== 6'b0) begin
               n_fails++;
               $display("FAIL reset_outputs t=%0t got ce=%b clr=%b run=%b hold=%b st=%b want all 0",
                        $time, sw_if.cnt_enable, sw_if.sw_clear, sw_if.running,
                        sw_if.lap_hold, sw_if.state);
            end
            prev_st = sw_if.state;
         end else if (done) begin
            n_tests++;
            if (exp_q.size() != 0) begin
               n_fails++;
               $display("FAIL pending_events got %0d left want 0 (next cyc=%0d)",
                        exp_q.size(), exp_q[0].cyc);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
            $finish;
         end else begin
            if (sw_if.cnt_enable || sw_if.sw_clear || (sw_if.state != prev_st)) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fails++;
                  $display("FAIL unexpected_event cyc=%0d ce=%b clr=%b st=%b hold=%b",
                           cyc, sw_if.cnt_enable, sw_if.sw_clear, sw_if.state, sw_if.lap_hold);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.ce !== sw_if.cnt_enable || e.clr !== sw_if.sw_clear ||
                      e.st !== sw_if.state || e.hold !== sw_if.lap_hold ||
                      e.run !== sw_if.running) begin
                     n_fails++;
                     $display("FAIL event got cyc=%0d ce=%b clr=%b st=%b hold=%b run=%b want cyc=%0d ce=%b clr=%b st=%b hold=%b run=%b",
                              cyc, sw_if.cnt_enable, sw_if.sw_clear, sw_if.state,
                              sw_if.lap_hold, sw_if.running,
                              e.cyc, e.ce, e.clr, e.st, e.hold, e.run);
                  end
               end
            end
            prev_st = sw_if.state;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got timeout at %0t want finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int b;
      int s;
      sw_if.btn_start = 1'b0;
      sw_if.btn_lap   = 1'b0;

      // Reset held with random button activity.
      repeat (10) begin
         @(negedge clk);
         sw_if.btn_start = 1'($urandom_range(0, 1));
         sw_if.btn_lap   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      sw_if.btn_start = 1'b0;
      sw_if.btn_lap   = 1'b0;
      #1 rst = 1'b1;
      b = cyc + 2;

      // Three-cycle glitch on start must be rejected.
      goto(b);
      sw_if.btn_start = 1'b1;
      goto(b + 3);
      sw_if.btn_start = 1'b0;

      // Lap in IDLE: clear pulse only.
      expect_ev(b + 28, 1'b0, 1'b1, 2'b00, 1'b0);
      press(b + 20, 1'b0, 1'b1);

      s = b + 50;
      // Start from IDLE: RUN at +8, ticks every 10 edges from +18.
      expect_ev(s + 8,  1'b0, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 18, 1'b1, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 28, 1'b1, 1'b0, 2'b01, 1'b0);
      press(s, 1'b1, 1'b0);

      // Pause with prescaler retained at 6.
      expect_ev(s + 34, 1'b0, 1'b0, 2'b10, 1'b0);
      press(s + 26, 1'b1, 1'b0);

      // Resume: first tick 4 edges after re-entering RUN.
      expect_ev(s + 58, 1'b0, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 62, 1'b1, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 72, 1'b1, 1'b0, 2'b01, 1'b0);
      press(s + 50, 1'b1, 1'b0);

      // Lap hold with unchanged tick cadence.
      expect_ev(s + 73, 1'b0, 1'b0, 2'b11, 1'b1);
      expect_ev(s + 82, 1'b1, 1'b0, 2'b11, 1'b1);
      expect_ev(s + 92, 1'b1, 1'b0, 2'b11, 1'b1);
      press(s + 65, 1'b0, 1'b1);

      expect_ev(s + 98,  1'b0, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 102, 1'b1, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 112, 1'b1, 1'b0, 2'b01, 1'b0);
      press(s + 90, 1'b0, 1'b1);

      // Start and lap together in RUN: PAUSE, no clear.
      expect_ev(s + 118, 1'b0, 1'b0, 2'b10, 1'b0);
      press(s + 110, 1'b1, 1'b1);

      // Lap in PAUSE: back to IDLE with a single clear pulse.
      expect_ev(s + 138, 1'b0, 1'b1, 2'b00, 1'b0);
      press(s + 130, 1'b0, 1'b1);

      // Restart proves the prescaler was zeroed by IDLE.
      expect_ev(s + 158, 1'b0, 1'b0, 2'b01, 1'b0);
      expect_ev(s + 168, 1'b1, 1'b0, 2'b01, 1'b0);
      press(s + 150, 1'b1, 1'b0);

      // Asynchronous reset while cnt_enable is high.
      goto(s + 168);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      goto(s + 200);
      #1 done = 1'b1;
   end

endmodule
